// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding CPU bus controller. Decodes the 8-bit
// address into ROM / RW RAM / output ports / input ports. Sequences the
// one-cycle synchronous memory latency through the states
// IDLE -> ACCESS -> CAPTURE -> READY.
module mem_bus_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_write,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       bus_error,
  output logic [7:0] mem_address,
  output logic       mem_write,
  output logic [7:0] mem_data_in,
  input  logic [7:0] rom_data,
  input  logic [7:0] rw_data,
  output logic [7:0] port_out_0,
  output logic [7:0] port_out_1,
  output logic [7:0] port_out_2,
  output logic [7:0] port_out_3,
  input  logic [7:0] port_in_0,
  input  logic [7:0] port_in_1,
  input  logic [7:0] port_in_2,
  input  logic [7:0] port_in_3
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, READY} state_t;

  state_t     state_reg, state_next;
  logic [7:0] addr_reg, wdata_reg, rdata_reg, rdata_next;
  logic       write_reg;
  logic [7:0] port_out_arr [4];
  logic [7:0] port_in_arr  [4];
  logic [7:0] port_sync_arr [4];

  // Region decode, always from the latched request
  logic in_rom, in_ram, in_oport, in_iport, in_hole, illegal;
  assign in_rom   = ~addr_reg[7];
  assign in_ram   = addr_reg[7] && (addr_reg < 8'd224);
  assign in_oport = (addr_reg[7:2] == 6'b111000);
  assign in_iport = (addr_reg[7:2] == 6'b111100);
  assign in_hole  = (addr_reg >= 8'd228) && (addr_reg <= 8'd239);
  assign illegal  = in_hole || (write_reg && (in_rom || (addr_reg >= 8'd240)));

  assign port_in_arr[0] = port_in_0;
  assign port_in_arr[1] = port_in_1;
  assign port_in_arr[2] = port_in_2;
  assign port_in_arr[3] = port_in_3;

  assign port_out_0 = port_out_arr[0];
  assign port_out_1 = port_out_arr[1];
  assign port_out_2 = port_out_arr[2];
  assign port_out_3 = port_out_arr[3];

  // The memory bus lines follow the latched request directly
  assign mem_address = addr_reg;
  assign mem_data_in = wdata_reg;
  assign cpu_rdata   = rdata_reg;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: only IDLE waits on the request
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cpu_req) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = READY;
      READY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state and the latched request
  always_comb begin
    cpu_ready = (state_reg == READY);
    bus_error = (state_reg == READY) && illegal;
    mem_write = (state_reg == ACCESS) && write_reg && in_ram;
  end

  // Latch the request when it is accepted out of IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg  <= 8'h00;
      wdata_reg <= 8'h00;
      write_reg <= 1'b0;
    end else if (state_reg == IDLE && cpu_req) begin
      addr_reg  <= cpu_addr;
      wdata_reg <= cpu_wdata;
      write_reg <= cpu_write;
    end
  end

  // Per-port output registers and two-stage input synchronizers
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_port
      logic [7:0] out_reg;
      logic [7:0] sync1_reg, sync2_reg;

      // Output port loads at the end of ACCESS for a store to its address
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          out_reg <= 8'h00;
        else if (state_reg == ACCESS && write_reg && in_oport && addr_reg[1:0] == 2'(gi))
          out_reg <= wdata_reg;
      end

      // Input port synchronizer; loads read the second stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg <= 8'h00;
          sync2_reg <= 8'h00;
        end else begin
          sync1_reg <= port_in_arr[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign port_out_arr[gi]  = out_reg;
      assign port_sync_arr[gi] = sync2_reg;
    end
  endgenerate

  // Read-data source select; unmapped addresses read as zero
  always_comb begin
    rdata_next = 8'h00;
    if (in_rom)        rdata_next = rom_data;
    else if (in_ram)   rdata_next = rw_data;
    else if (in_oport) rdata_next = port_out_arr[addr_reg[1:0]];
    else if (in_iport) rdata_next = port_sync_arr[addr_reg[1:0]];
  end

  // Load data is captured at the end of CAPTURE; stores leave it untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rdata_reg <= 8'h00;
    else if (state_reg == CAPTURE && !write_reg)
      rdata_reg <= rdata_next;
  end

endmodule
